// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the access FSM encoding and the byte-enable size masks.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  localparam logic [7:0] BE_BYTE   = 8'h01;
  localparam logic [7:0] BE_HALF   = 8'h03;
  localparam logic [7:0] BE_WORD   = 8'h0F;
  localparam logic [7:0] BE_DOUBLE = 8'hFF;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shift the read doubleword down to the
// addressed byte, then zero- or sign-extend from the access size.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [7:0]      byte_enable,
  input  logic            ext_un,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data_o = shifted;
    case (byte_enable)
      BE_BYTE:
        data_o = {{(XLEN-8){~ext_un & shifted[7]}},
                  shifted[7:0]};
      BE_HALF:
        data_o = {{(XLEN-16){~ext_un & shifted[15]}},
                  shifted[15:0]};
      BE_WORD:
        data_o = {{(XLEN-32){~ext_un & shifted[31]}},
                  shifted[31:0]};
      default:
        data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory req/gnt/rvalid port,
// stalls upstream while an access is in flight, aligns load data.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int SIZE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              me_mem_rena,
  input  logic              me_mem_wena,
  input  logic              me_mem_ext_un,
  input  logic              me_mem_to_reg,
  input  logic [SIZE_W-1:0] me_mem_byte_enable,
  input  logic [XLEN-1:0]   me_alu_result,
  input  logic [XLEN-1:0]   me_new_rs2_data,
  input  logic              me_rd_wena,
  input  logic [4:0]        me_rd_waddr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [SIZE_W-1:0] dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_rd_wena,
  output logic [4:0]        mem_rd_waddr,
  output logic [XLEN-1:0]   mem_rd_wdata,
  output logic              mem_misalign,
  output logic              mem_stall_req
);

  mem_state_e        state_q, state_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              access;
  logic              misalign;
  logic              go;
  logic [2:0]        off;
  logic [2*SIZE_W-1:0] be_wide;
  logic [XLEN-1:0]   load_data;

  assign access = me_mem_rena | me_mem_wena;
  assign off    = me_alu_result[2:0];

  // Upper half non-zero means the mask spilled past the doubleword.
  assign be_wide  = {{SIZE_W{1'b0}}, me_mem_byte_enable} << off;
  assign misalign = access & (|be_wide[2*SIZE_W-1:SIZE_W]);
  assign go       = access & ~misalign;

  assign dmem_we    = me_mem_wena;
  assign dmem_addr  = {me_alu_result[XLEN-1:3], 3'b000};
  assign dmem_wdata = me_new_rs2_data << {off, 3'b000};
  assign dmem_wstrb = be_wide[SIZE_W-1:0];

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    dmem_req = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (go) begin
          dmem_req = 1'b1;
          if (dmem_gnt)
            state_d = me_mem_wena ? MEM_DONE : MEM_WAIT;
          else
            state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt)
          state_d = me_mem_wena ? MEM_DONE : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata      (rdata_q),
    .off        (off),
    .byte_enable(me_mem_byte_enable),
    .ext_un     (me_mem_ext_un),
    .data_o     (load_data)
  );

  assign mem_stall_req = ((state_q == MEM_IDLE) & go)
                       | (state_q == MEM_REQ)
                       | (state_q == MEM_WAIT);

  assign mem_rd_wdata = me_mem_to_reg ? load_data : me_alu_result;
  assign mem_rd_wena  = me_rd_wena & ~misalign;
  assign mem_rd_waddr = me_rd_waddr;
  assign mem_misalign = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads,
// misalignment, spurious rvalid and reset during an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        me_mem_rena;
  logic        me_mem_wena;
  logic        me_mem_ext_un;
  logic        me_mem_to_reg;
  logic [7:0]  me_mem_byte_enable;
  logic [63:0] me_alu_result;
  logic [63:0] me_new_rs2_data;
  logic        me_rd_wena;
  logic [4:0]  me_rd_waddr;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        mem_rd_wena;
  logic [4:0]  mem_rd_waddr;
  logic [63:0] mem_rd_wdata;
  logic        mem_misalign;
  logic        mem_stall_req;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .me_mem_rena       (me_mem_rena),
    .me_mem_wena       (me_mem_wena),
    .me_mem_ext_un     (me_mem_ext_un),
    .me_mem_to_reg     (me_mem_to_reg),
    .me_mem_byte_enable(me_mem_byte_enable),
    .me_alu_result     (me_alu_result),
    .me_new_rs2_data   (me_new_rs2_data),
    .me_rd_wena        (me_rd_wena),
    .me_rd_waddr       (me_rd_waddr),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_wstrb        (dmem_wstrb),
    .dmem_gnt          (dmem_gnt),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .mem_rd_wena       (mem_rd_wena),
    .mem_rd_waddr      (mem_rd_waddr),
    .mem_rd_wdata      (mem_rd_wdata),
    .mem_misalign      (mem_misalign),
    .mem_stall_req     (mem_stall_req)
  );

  task automatic clear_inputs();
    me_mem_rena        = 1'b0;
    me_mem_wena        = 1'b0;
    me_mem_ext_un      = 1'b0;
    me_mem_to_reg      = 1'b0;
    me_mem_byte_enable = 8'h00;
    me_alu_result      = 64'h0;
    me_new_rs2_data    = 64'h0;
    me_rd_wena         = 1'b0;
    me_rd_waddr        = 5'd0;
    dmem_gnt           = 1'b0;
    dmem_rvalid        = 1'b0;
    dmem_rdata         = 64'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and run it until the stall drops.
  // gnt is given in cycle gnt_cyc, rvalid in cycle rv_cyc.
  task automatic do_access(
    input  logic [63:0] addr,
    input  logic [7:0]  be,
    input  logic        rena,
    input  logic        wena,
    input  logic        un,
    input  logic [63:0] rs2,
    input  int          gnt_cyc,
    input  int          rv_cyc,
    input  logic [63:0] rdata,
    output int          stalls,
    output logic [63:0] wdata,
    output logic        wena_o
  );
    me_mem_rena        = rena;
    me_mem_wena        = wena;
    me_mem_ext_un      = un;
    me_mem_to_reg      = rena;
    me_mem_byte_enable = be;
    me_alu_result      = addr;
    me_new_rs2_data    = rs2;
    me_rd_wena         = rena;
    me_rd_waddr        = 5'd9;
    dmem_rdata         = rdata;
    stalls = 0;
    for (int c = 0; c < 30; c++) begin
      dmem_gnt    = (c == gnt_cyc);
      dmem_rvalid = (c == rv_cyc);
      #2;
      if (!mem_stall_req) break;
      stalls++;
      next_cycle();
    end
    wdata  = mem_rd_wdata;
    wena_o = mem_rd_wena;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got=%b exp=0", dmem_req);
    end
    checks++;
    if (mem_stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", mem_stall_req);
    end
    checks++;
    if (mem_rd_wena !== 1'b0) begin
      errors++; $display("FAIL reset_wena got=%b exp=0", mem_rd_wena);
    end
    checks++;
    if (mem_rd_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_wdata got=%h exp=0", mem_rd_wdata);
    end
    checks++;
    if (mem_misalign !== 1'b0) begin
      errors++; $display("FAIL reset_misalign got=%b exp=0", mem_misalign);
    end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_alu();
    me_alu_result = 64'h1234;
    me_rd_wena    = 1'b1;
    me_rd_waddr   = 5'd5;
    #2;
    checks++;
    if (mem_rd_wdata !== 64'h1234) begin
      errors++; $display("FAIL alu_wdata got=%h exp=1234", mem_rd_wdata);
    end
    checks++;
    if (mem_stall_req !== 1'b0) begin
      errors++; $display("FAIL alu_stall got=%b exp=0", mem_stall_req);
    end
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL alu_req got=%b exp=0", dmem_req);
    end
    checks++;
    if (mem_rd_wena !== 1'b1 || mem_rd_waddr !== 5'd5) begin
      errors++;
      $display("FAIL alu_rd got=%b/%0d exp=1/5", mem_rd_wena, mem_rd_waddr);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_store_sb();
    me_mem_wena        = 1'b1;
    me_mem_byte_enable = 8'h01;
    me_alu_result      = 64'h1003;
    me_new_rs2_data    = 64'hAB;
    dmem_gnt           = 1'b1;
    #2;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      errors++; $display("FAIL sb_req got=%b/%b exp=1/1", dmem_req, dmem_we);
    end
    checks++;
    if (dmem_addr !== 64'h1000) begin
      errors++; $display("FAIL sb_addr got=%h exp=1000", dmem_addr);
    end
    checks++;
    if (dmem_wstrb !== 8'h08) begin
      errors++; $display("FAIL sb_wstrb got=%h exp=08", dmem_wstrb);
    end
    checks++;
    if (dmem_wdata !== 64'hAB00_0000) begin
      errors++; $display("FAIL sb_wdata got=%h exp=ab000000", dmem_wdata);
    end
    checks++;
    if (mem_stall_req !== 1'b1) begin
      errors++; $display("FAIL sb_stall0 got=%b exp=1", mem_stall_req);
    end
    next_cycle();
    dmem_gnt = 1'b0;
    #2;
    checks++;
    if (mem_stall_req !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sb_done got=%b/%b exp=0/0", mem_stall_req, dmem_req);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_loads();
    int st;
    logic [63:0] wd;
    logic we;
    do_access(64'h2006, 8'h03, 1'b1, 1'b0, 1'b0, 64'h0, 3, 5,
              64'h8001_0000_0000_0000, st, wd, we);
    checks++;
    if (st !== 6) begin
      errors++; $display("FAIL lh_stall got=%0d exp=6", st);
    end
    checks++;
    if (wd !== 64'hFFFF_FFFF_FFFF_8001) begin
      errors++; $display("FAIL lh_data got=%h exp=ffffffffffff8001", wd);
    end
    checks++;
    if (we !== 1'b1) begin
      errors++; $display("FAIL lh_wena got=%b exp=1", we);
    end
    do_access(64'h2004, 8'h0F, 1'b1, 1'b0, 1'b1, 64'h0, 0, 1,
              64'hF000_0000_0000_0000, st, wd, we);
    checks++;
    if (st !== 2) begin
      errors++; $display("FAIL lwu_stall got=%0d exp=2", st);
    end
    checks++;
    if (wd !== 64'h0000_0000_F000_0000) begin
      errors++; $display("FAIL lwu_data got=%h exp=00000000f0000000", wd);
    end
    do_access(64'h1001, 8'h01, 1'b1, 1'b0, 1'b0, 64'h0, 0, 1,
              64'h0000_0000_0000_8000, st, wd, we);
    checks++;
    if (wd !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", wd);
    end
    do_access(64'h1001, 8'h01, 1'b1, 1'b0, 1'b1, 64'h0, 0, 1,
              64'h0000_0000_0000_8000, st, wd, we);
    checks++;
    if (wd !== 64'h80) begin
      errors++; $display("FAIL lbu_data got=%h exp=80", wd);
    end
  endtask

  task automatic test_misalign();
    me_mem_rena        = 1'b1;
    me_mem_to_reg      = 1'b1;
    me_mem_byte_enable = 8'h0F;
    me_alu_result      = 64'h2006;
    me_rd_wena         = 1'b1;
    me_rd_waddr        = 5'd3;
    dmem_gnt           = 1'b1;
    #2;
    checks++;
    if (mem_misalign !== 1'b1) begin
      errors++; $display("FAIL mis_flag got=%b exp=1", mem_misalign);
    end
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL mis_req got=%b exp=0", dmem_req);
    end
    checks++;
    if (mem_rd_wena !== 1'b0) begin
      errors++; $display("FAIL mis_wena got=%b exp=0", mem_rd_wena);
    end
    checks++;
    if (mem_stall_req !== 1'b0) begin
      errors++; $display("FAIL mis_stall got=%b exp=0", mem_stall_req);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_spurious_rvalid();
    int st;
    logic [63:0] wd;
    logic we;
    do_access(64'h3000, 8'hFF, 1'b0, 1'b1, 1'b0, 64'h55, 2, 0,
              64'hDEAD_BEEF_DEAD_BEEF, st, wd, we);
    checks++;
    if (st !== 3) begin
      errors++; $display("FAIL sd_stall got=%0d exp=3", st);
    end
    // Ignored rvalid must leave the captured load word at its old value.
    me_mem_to_reg      = 1'b1;
    me_mem_byte_enable = 8'h01;
    me_alu_result      = 64'h1001;
    me_mem_ext_un      = 1'b1;
    #2;
    checks++;
    if (mem_rd_wdata !== 64'h80) begin
      errors++; $display("FAIL sd_rdata got=%h exp=80", mem_rd_wdata);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int st;
    logic [63:0] wd;
    logic we;
    me_mem_rena        = 1'b1;
    me_mem_to_reg      = 1'b1;
    me_mem_byte_enable = 8'hFF;
    me_alu_result      = 64'h2000;
    me_rd_wena         = 1'b1;
    me_rd_waddr        = 5'd4;
    dmem_gnt           = 1'b1;
    next_cycle();
    dmem_gnt = 1'b0;
    #2;
    checks++;
    if (mem_stall_req !== 1'b1) begin
      errors++; $display("FAIL rm_wait got=%b exp=1", mem_stall_req);
    end
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    me_mem_to_reg      = 1'b1;
    me_mem_byte_enable = 8'hFF;
    dmem_rvalid        = 1'b1;
    dmem_rdata         = 64'hCAFE_CAFE_CAFE_CAFE;
    #2;
    checks++;
    if (mem_stall_req !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rm_idle got=%b/%b exp=0/0", mem_stall_req, dmem_req);
    end
    checks++;
    if (mem_rd_wdata !== 64'h0 || mem_rd_wena !== 1'b0
        || mem_rd_waddr !== 5'd0) begin
      errors++;
      $display("FAIL rm_outs got=%h/%b/%0d exp=0/0/0",
               mem_rd_wdata, mem_rd_wena, mem_rd_waddr);
    end
    next_cycle();
    #2;
    checks++;
    if (mem_rd_wdata !== 64'h0) begin
      errors++; $display("FAIL rm_late_rv got=%h exp=0", mem_rd_wdata);
    end
    clear_inputs();
    do_access(64'h2008, 8'hFF, 1'b1, 1'b0, 1'b0, 64'h0, 0, 1,
              64'h0123_4567_89AB_CDEF, st, wd, we);
    checks++;
    if (st !== 2) begin
      errors++; $display("FAIL rm_ld_stall got=%0d exp=2", st);
    end
    checks++;
    if (wd !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL rm_ld_data got=%h exp=0123456789abcdef", wd);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_loads();
    test_misalign();
    test_spurious_rvalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
